// File: rtl/mmio_bram_arbiter.sv
// Purpose : share one BRAM (1 write port, 1 read port) between host MMIO and a kernel requester.
// Latency : writes reach the BRAM 1 cycle after the request; read data returns 1+BRAM_RD_LATENCY cycles after it.
// Backpr. : host is never stalled; kernel is held off (kern_req_ready=0) only on a port or same-address conflict.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   host_wr_en/host_rd_en/host_addr   host MMIO access (one shared address), host_wr_data
//   host_rd_valid/host_rd_data        host read response
//   kern_req_valid/ready/wr/addr/wr_data   kernel valid/ready request channel
//   kern_rd_valid/kern_rd_data        kernel read response (no back-pressure)
//   bram_wr_en/addr/data, bram_rd_addr    registered BRAM control
//   bram_rd_data                      BRAM read data
//   stat_clr, kern_stall_count, kern_accept_count   saturating statistics
module mmio_bram_arbiter #(
  parameter int ADDR_WIDTH      = 9,
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_RD_LATENCY = 1,   // must be >= 1
  parameter int CNT_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  host_wr_en,
  input  logic                  host_rd_en,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_rd_valid,
  output logic [DATA_WIDTH-1:0] host_rd_data,

  input  logic                  kern_req_valid,
  input  logic                  kern_req_wr,
  input  logic [ADDR_WIDTH-1:0] kern_addr,
  input  logic [DATA_WIDTH-1:0] kern_wr_data,
  output logic                  kern_req_ready,
  output logic                  kern_rd_valid,
  output logic [DATA_WIDTH-1:0] kern_rd_data,

  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,

  input  logic                  stat_clr,
  output logic [CNT_WIDTH-1:0]  kern_stall_count,
  output logic [CNT_WIDTH-1:0]  kern_accept_count
);

  // One stage for the registered read address plus one per BRAM latency cycle.
  localparam int TAG_DEPTH = BRAM_RD_LATENCY + 1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Kernel admission
  // ---------------------------------------------------------------------------
  logic same_addr;
  logic kern_wr_ready;
  logic kern_rd_ready;
  logic kern_acc;
  logic kern_wr_acc;
  logic kern_rd_acc;
  logic kern_stall;
  logic rd_issue;

  assign same_addr     = (host_addr == kern_addr);
  assign kern_wr_ready = !host_wr_en;
  // Holding off a kernel read of the word the host is writing right now keeps
  // the kernel away from the BRAM's read-during-write behaviour entirely.
  assign kern_rd_ready = !host_rd_en && !(host_wr_en && same_addr);

  // Depends only on host inputs and the kernel's request fields, never on
  // kern_req_valid, so it is meaningful even when no request is present.
  assign kern_req_ready = kern_req_wr ? kern_wr_ready : kern_rd_ready;

  assign kern_acc    = kern_req_valid && kern_req_ready;
  assign kern_wr_acc = kern_acc && kern_req_wr;
  assign kern_rd_acc = kern_acc && !kern_req_wr;
  assign kern_stall  = kern_req_valid && !kern_req_ready;
  assign rd_issue    = host_rd_en || kern_rd_acc;

  // ---------------------------------------------------------------------------
  // Registered BRAM write port (host has priority)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
    end else begin
      bram_wr_en <= host_wr_en || kern_wr_acc;
      if (host_wr_en) begin
        bram_wr_addr <= host_addr;
        bram_wr_data <= host_wr_data;
      end else if (kern_wr_acc) begin
        bram_wr_addr <= kern_addr;
        bram_wr_data <= kern_wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered BRAM read address (host has priority). The address simply holds
  // when nothing is issued; the tag pipeline decides whether data is wanted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_rd_addr <= '0;
    end else if (host_rd_en) begin
      bram_rd_addr <= host_addr;
    end else if (kern_rd_acc) begin
      bram_rd_addr <= kern_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Response tag pipeline: bit 0 is loaded alongside bram_rd_addr, the top bit
  // lines up with bram_rd_data for that read. Owner bit: 1 = kernel.
  // ---------------------------------------------------------------------------
  logic [TAG_DEPTH-1:0] tag_vld;
  logic [TAG_DEPTH-1:0] tag_kern;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld  <= '0;
      tag_kern <= '0;
    end else begin
      tag_vld  <= {tag_vld[TAG_DEPTH-2:0],  rd_issue};
      tag_kern <= {tag_kern[TAG_DEPTH-2:0], !host_rd_en};
    end
  end

  assign host_rd_valid = tag_vld[TAG_DEPTH-1] && !tag_kern[TAG_DEPTH-1];
  assign kern_rd_valid = tag_vld[TAG_DEPTH-1] &&  tag_kern[TAG_DEPTH-1];
  assign host_rd_data  = bram_rd_data;
  assign kern_rd_data  = bram_rd_data;

  // ---------------------------------------------------------------------------
  // Saturating statistics; clear beats increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kern_stall_count  <= '0;
      kern_accept_count <= '0;
    end else if (stat_clr) begin
      kern_stall_count  <= '0;
      kern_accept_count <= '0;
    end else begin
      if (kern_stall && (kern_stall_count != CNT_MAX))
        kern_stall_count <= kern_stall_count + CNT_ONE;
      if (kern_acc && (kern_accept_count != CNT_MAX))
        kern_accept_count <= kern_accept_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mmio_bram_arbiter.sv
// Purpose : self-checking bench for mmio_bram_arbiter with a BRAM model and a transaction-level scoreboard.
// Latency : drives inputs on the falling edge, samples 1 ns before the rising edge.
// Backpr. : kernel stimulus holds each request until kern_req_ready is seen high.
module tb_mmio_bram_arbiter;

  localparam int AW = 9;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_wr_en = 1'b0, host_rd_en = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          host_rd_valid;
  logic [DW-1:0] host_rd_data;
  logic          kern_req_valid = 1'b0, kern_req_wr = 1'b0;
  logic [AW-1:0] kern_addr = '0;
  logic [DW-1:0] kern_wr_data = '0;
  logic          kern_req_ready, kern_rd_valid;
  logic [DW-1:0] kern_rd_data;
  logic          bram_wr_en;
  logic [AW-1:0] bram_wr_addr, bram_rd_addr;
  logic [DW-1:0] bram_wr_data;
  logic [DW-1:0] bram_rd_data;
  logic          stat_clr = 1'b0;
  logic [31:0]   kern_stall_count, kern_accept_count;

  // Second instance with 4-bit counters, sharing all inputs.
  logic          sm_host_rd_valid, sm_kern_req_ready, sm_kern_rd_valid, sm_bram_wr_en;
  logic [DW-1:0] sm_host_rd_data, sm_kern_rd_data, sm_bram_wr_data;
  logic [AW-1:0] sm_bram_wr_addr, sm_bram_rd_addr;
  logic [3:0]    sm_stall_count, sm_accept_count;

  always #5 clk = ~clk;

  mmio_bram_arbiter dut (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_rd_en(host_rd_en), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
    .kern_req_valid(kern_req_valid), .kern_req_wr(kern_req_wr), .kern_addr(kern_addr),
    .kern_wr_data(kern_wr_data), .kern_req_ready(kern_req_ready),
    .kern_rd_valid(kern_rd_valid), .kern_rd_data(kern_rd_data),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .stat_clr(stat_clr), .kern_stall_count(kern_stall_count), .kern_accept_count(kern_accept_count)
  );

  mmio_bram_arbiter #(.CNT_WIDTH(4)) dut_sm (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_rd_en(host_rd_en), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_rd_valid(sm_host_rd_valid), .host_rd_data(sm_host_rd_data),
    .kern_req_valid(kern_req_valid), .kern_req_wr(kern_req_wr), .kern_addr(kern_addr),
    .kern_wr_data(kern_wr_data), .kern_req_ready(sm_kern_req_ready),
    .kern_rd_valid(sm_kern_rd_valid), .kern_rd_data(sm_kern_rd_data),
    .bram_wr_en(sm_bram_wr_en), .bram_wr_addr(sm_bram_wr_addr), .bram_wr_data(sm_bram_wr_data),
    .bram_rd_addr(sm_bram_rd_addr), .bram_rd_data(bram_rd_data),
    .stat_clr(stat_clr), .kern_stall_count(sm_stall_count), .kern_accept_count(sm_accept_count)
  );

  // Power-up content of every word, until something writes it.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 64'hC0DE_0000_0000_0000 | (64'(a) * 64'd3 + 64'd1);
  endfunction

  // BRAM model: read-first, 1 cycle read latency.
  logic [DW-1:0] mem     [512];
  bit            mem_wr  [512];
  always @(posedge clk) begin
    bram_rd_data <= mem_wr[bram_rd_addr] ? mem[bram_rd_addr] : init_val(bram_rd_addr);
    if (bram_wr_en) begin
      mem[bram_wr_addr]    <= bram_wr_data;
      mem_wr[bram_wr_addr] <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard. Transaction view: a read requested in cycle k returns, two
  // cycles later, the memory content left by all writes requested before k.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  rsp_t          hq[$];
  rsp_t          kq[$];
  logic [DW-1:0] shadow    [512];
  bit            shadow_wr [512];
  int            cyc = 0;
  bit            exp_wr = 0, exp_rd = 0;
  logic [AW-1:0] exp_wa = '0, exp_ra = '0;
  logic [DW-1:0] exp_wd = '0;
  logic [31:0]   m_stall = '0, m_acc = '0;

  function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
    return shadow_wr[a] ? shadow[a] : init_val(a);
  endfunction

  always begin
    logic ready_m, acc, exp_h, exp_k;
    @(negedge clk);
    #4;
    cyc++;
    if (rst) begin
      hq.delete();
      kq.delete();
      exp_wr  = 0;
      exp_rd  = 0;
      m_stall = '0;
      m_acc   = '0;
    end else begin
      // Outputs produced by earlier cycles.
      check("sb_bram_wr_en", bram_wr_en, exp_wr);
      if (exp_wr) begin
        check("sb_bram_wr_addr", bram_wr_addr, exp_wa);
        check("sb_bram_wr_data", bram_wr_data, exp_wd);
      end
      if (exp_rd) check("sb_bram_rd_addr", bram_rd_addr, exp_ra);
      exp_h = (hq.size() > 0) && (hq[0].due == cyc);
      exp_k = (kq.size() > 0) && (kq[0].due == cyc);
      check("sb_host_rd_valid", host_rd_valid, exp_h);
      check("sb_kern_rd_valid", kern_rd_valid, exp_k);
      if (exp_h) begin
        check("sb_host_rd_data", host_rd_data, hq[0].data);
        void'(hq.pop_front());
      end
      if (exp_k) begin
        check("sb_kern_rd_data", kern_rd_data, kq[0].data);
        void'(kq.pop_front());
      end
      check("sb_stall_count", kern_stall_count, m_stall);
      check("sb_accept_count", kern_accept_count, m_acc);

      // This cycle's request.
      if (kern_req_wr) ready_m = !host_wr_en;
      else             ready_m = !host_rd_en && !(host_wr_en && host_addr == kern_addr);
      check("sb_kern_req_ready", kern_req_ready, ready_m);
      acc = kern_req_valid && ready_m;

      exp_rd = host_rd_en || (acc && !kern_req_wr);
      if (host_rd_en) begin
        hq.push_back('{data: shadow_rd(host_addr), due: cyc + 2});
        exp_ra = host_addr;
      end else if (acc && !kern_req_wr) begin
        kq.push_back('{data: shadow_rd(kern_addr), due: cyc + 2});
        exp_ra = kern_addr;
      end

      exp_wr = host_wr_en || (acc && kern_req_wr);
      if (host_wr_en) begin
        exp_wa = host_addr;
        exp_wd = host_wr_data;
      end else if (acc && kern_req_wr) begin
        exp_wa = kern_addr;
        exp_wd = kern_wr_data;
      end
      if (exp_wr) begin
        shadow[exp_wa]    = exp_wd;
        shadow_wr[exp_wa] = 1'b1;
      end

      if (stat_clr) begin
        m_stall = '0;
        m_acc   = '0;
      end else begin
        if (kern_req_valid && !ready_m && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (acc && m_acc != 32'hFFFF_FFFF) m_acc++;
      end
    end
  end

  int hv_pulses = 0;
  always @(negedge clk) if (host_rd_valid === 1'b1) hv_pulses <= hv_pulses + 1;

  task automatic idle();
    host_wr_en     = 1'b0;
    host_rd_en     = 1'b0;
    kern_req_valid = 1'b0;
    stat_clr       = 1'b0;
  endtask

  typedef struct {
    logic          hw, hr;
    logic [AW-1:0] ha;
    logic          kw;
    logic [AW-1:0] ka;
    logic          exp_rdy;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int bad, p0;
    bit pend;

    vecs[0] = '{hw:0, hr:0, ha:9'd0,   kw:0, ka:9'd1,   exp_rdy:1};
    vecs[1] = '{hw:0, hr:0, ha:9'd0,   kw:1, ka:9'd1,   exp_rdy:1};
    vecs[2] = '{hw:1, hr:0, ha:9'd10,  kw:1, ka:9'd2,   exp_rdy:0};
    vecs[3] = '{hw:1, hr:0, ha:9'd10,  kw:0, ka:9'd11,  exp_rdy:1};
    vecs[4] = '{hw:1, hr:0, ha:9'd10,  kw:0, ka:9'd10,  exp_rdy:0};
    vecs[5] = '{hw:0, hr:1, ha:9'd0,   kw:0, ka:9'd5,   exp_rdy:0};
    vecs[6] = '{hw:0, hr:1, ha:9'd0,   kw:1, ka:9'd0,   exp_rdy:1};
    vecs[7] = '{hw:1, hr:1, ha:9'd511, kw:0, ka:9'd12,  exp_rdy:0};
    vecs[8] = '{hw:1, hr:0, ha:9'd511, kw:0, ka:9'd511, exp_rdy:0};
    vecs[9] = '{hw:1, hr:0, ha:9'd0,   kw:0, ka:9'd511, exp_rdy:1};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_bram_wr_en", bram_wr_en, 0);
    check("rst_bram_wr_addr", bram_wr_addr, 0);
    check("rst_bram_wr_data", bram_wr_data, 0);
    check("rst_bram_rd_addr", bram_rd_addr, 0);
    check("rst_host_rd_valid", host_rd_valid, 0);
    check("rst_kern_rd_valid", kern_rd_valid, 0);
    check("rst_stall_count", kern_stall_count, 0);
    check("rst_accept_count", kern_accept_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Ready rules, no request present.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      host_wr_en = vecs[i].hw; host_rd_en = vecs[i].hr; host_addr = vecs[i].ha;
      host_wr_data = 64'h1111_0000 + 64'(i);
      kern_req_valid = 1'b0; kern_req_wr = vecs[i].kw; kern_addr = vecs[i].ka;
      #1 check($sformatf("vec%0d_ready", i), kern_req_ready, vecs[i].exp_rdy);
    end
    @(negedge clk); idle(); stat_clr = 1'b1;

    // Host read priority.
    @(negedge clk);
    stat_clr = 1'b0; host_rd_en = 1'b1; host_addr = 9'd5;
    kern_req_valid = 1'b1; kern_req_wr = 1'b0; kern_addr = 9'd7;
    #1 check("prio_ready_blocked", kern_req_ready, 0);
    @(negedge clk);
    check("prio_rd_addr_host", bram_rd_addr, 5);
    check("prio_stall_count", kern_stall_count, 1);
    host_rd_en = 1'b0;
    #1 check("prio_ready_free", kern_req_ready, 1);
    @(negedge clk);
    check("prio_host_valid", host_rd_valid, 1);
    check("prio_host_data", host_rd_data, init_val(9'd5));
    check("prio_rd_addr_kern", bram_rd_addr, 7);
    idle();
    @(negedge clk);
    check("prio_kern_valid", kern_rd_valid, 1);
    check("prio_kern_data", kern_rd_data, init_val(9'd7));
    check("prio_accept_count", kern_accept_count, 1);

    // Host write and kernel read of the same word.
    @(negedge clk);
    host_wr_en = 1'b1; host_addr = 9'd3; host_wr_data = 64'hDEAD_BEEF;
    kern_req_valid = 1'b1; kern_req_wr = 1'b0; kern_addr = 9'd3;
    #1 check("par_ready_blocked", kern_req_ready, 0);
    @(negedge clk);
    host_wr_en = 1'b0;
    #1 check("par_ready_free", kern_req_ready, 1);
    @(negedge clk); idle();
    @(negedge clk);
    check("par_kern_valid", kern_rd_valid, 1);
    check("par_kern_data", kern_rd_data, 64'hDEAD_BEEF);

    // Host write and kernel read of different words, same cycle.
    @(negedge clk);
    host_wr_en = 1'b1; host_addr = 9'd3; host_wr_data = 64'h1234_5678;
    kern_req_valid = 1'b1; kern_req_wr = 1'b0; kern_addr = 9'd4;
    #1 check("diff_ready", kern_req_ready, 1);
    @(negedge clk); idle();
    @(negedge clk);
    check("diff_kern_valid", kern_rd_valid, 1);
    check("diff_kern_data", kern_rd_data, init_val(9'd4));

    // Counter saturation (4-bit instance) and clear during a stall.
    @(negedge clk); idle(); stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0; host_rd_en = 1'b1; host_addr = 9'd20;
    kern_req_valid = 1'b1; kern_req_wr = 1'b0; kern_addr = 9'd21;
    repeat (20) @(negedge clk);
    check("sat_small_stall", sm_stall_count, 15);
    check("sat_main_stall", kern_stall_count, 20);
    stat_clr = 1'b1;
    @(negedge clk);
    check("clr_small_stall", sm_stall_count, 0);
    check("clr_main_stall", kern_stall_count, 0);
    stat_clr = 1'b0; host_rd_en = 1'b0;
    @(negedge clk); idle(); stat_clr = 1'b1;

    // Back-to-back kernel stream: 512 writes (data = addr), then 512 reads.
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      stat_clr = 1'b0;
      kern_req_valid = 1'b1; kern_req_wr = (i < 512);
      kern_addr = 9'(i); kern_wr_data = 64'(i % 512);
      #1 if (kern_req_ready !== 1'b1) bad++;
    end
    @(negedge clk); idle();
    check("stream_ready_drops", bad, 0);
    check("stream_accept_count", kern_accept_count, 1024);
    repeat (4) @(negedge clk);

    // Reset while a host read is in flight.
    @(negedge clk); host_rd_en = 1'b1; host_addr = 9'd9;
    @(negedge clk); idle(); p0 = hv_pulses; rst = 1'b1;
    #1;
    check("mid_rst_wr_en", bram_wr_en, 0);
    check("mid_rst_wr_addr", bram_wr_addr, 0);
    check("mid_rst_wr_data", bram_wr_data, 0);
    check("mid_rst_rd_addr", bram_rd_addr, 0);
    check("mid_rst_stall", kern_stall_count, 0);
    check("mid_rst_accept", kern_accept_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_no_host_valid", hv_pulses - p0, 0);

    // Random traffic against the scoreboard.
    pend = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      host_rd_en   = ($urandom_range(0, 9) < 3);
      host_wr_en   = ($urandom_range(0, 9) < 3);
      host_addr    = ($urandom_range(0, 15) == 0) ? 9'd511 : 9'($urandom_range(0, 7));
      host_wr_data = {$urandom, $urandom};
      stat_clr     = ($urandom_range(0, 99) == 0);
      if (!pend && $urandom_range(0, 9) < 7) begin
        pend         = 1;
        kern_req_wr  = $urandom_range(0, 1) == 1;
        kern_addr    = ($urandom_range(0, 15) == 0) ? 9'd0 : 9'($urandom_range(0, 7));
        kern_wr_data = {$urandom, $urandom};
      end
      kern_req_valid = pend;
      #1 if (pend && kern_req_ready) pend = 0;
    end
    @(negedge clk); idle();
    repeat (5) @(negedge clk);
    check("sb_drained", hq.size() + kq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
